// File: rtl/ac_motor_control_sector_switch_pkg.sv
// Shared definitions for the AC motor sector switch block.
// Contents:
//   - field widths and the bit positions inside mod_delay_umin
//   - switching vector encodings V0..V7, ordered {s1, s2, s3}
//   - sector helpers (wrap 5 -> 0, vector selection)
//   - sine_entry(): elaboration-time generator for the 60-degree sine table
package ac_motor_control_sector_switch_pkg;

  localparam int POWER_W    = 12;
  localparam int CTRL_W     = 16;
  localparam int ACC_W      = 20;
  localparam int SINE_W     = 12;
  localparam int DELAY_W    = 8;
  localparam int UMIN_W     = 7;
  localparam int SECTOR_W   = 3;
  localparam int ANGLE_W    = 8;
  localparam int SECTOR_COUNT = 6;

  // Field offsets inside mod_delay_umin.
  localparam int MOD_BIT    = 15;
  localparam int DELAY_MSB  = 14;
  localparam int DELAY_LSB  = 7;
  localparam int UMIN_MSB   = 6;
  localparam int UMIN_LSB   = 0;
  // u_min is given in units of 32 amplitude steps.
  localparam int UMIN_SHIFT = 5;

  localparam logic [SECTOR_W-1:0] SECTOR_LAST = 3'(SECTOR_COUNT - 1);

  // Vector encodings, {s1, s2, s3}; 1 = high side switch on.
  localparam logic [2:0] V0 = 3'b000;
  localparam logic [2:0] V1 = 3'b100;
  localparam logic [2:0] V2 = 3'b110;
  localparam logic [2:0] V3 = 3'b010;
  localparam logic [2:0] V4 = 3'b011;
  localparam logic [2:0] V5 = 3'b001;
  localparam logic [2:0] V6 = 3'b101;
  localparam logic [2:0] V7 = 3'b111;

  function automatic logic [2:0] vector_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = V0;
      3'd1:    code = V1;
      3'd2:    code = V2;
      3'd3:    code = V3;
      3'd4:    code = V4;
      3'd5:    code = V5;
      3'd6:    code = V6;
      default: code = V7;
    endcase
    return code;
  endfunction

  function automatic logic [SECTOR_W-1:0] next_sector(input logic [SECTOR_W-1:0] s);
    return (s == SECTOR_LAST) ? '0 : s + 3'd1;
  endfunction

  // pi scaled by 2^30, used by the fixed-point Taylor series below.
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(4095 * sin(60deg * idx / 256)), evaluated at elaboration.
  // Angle in Q30 radians is pi*idx/768; sine via 8 Taylor terms.
  // A small positive bias resolves the exact tie at idx=128
  // (sin 30deg = 0.5 -> 2047.5) upward despite truncation noise.
  function automatic logic [SINE_W-1:0] sine_entry(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    x    = (PI_Q30 * longint'(idx)) / 64'sd768;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x2) >>> 30;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    scaled = (sum * 64'sd4095 + (64'sd1 <<< 29) + (64'sd1 <<< 17)) >>> 30;
    if (scaled < 0)
      scaled = 0;
    if (scaled > 64'sd4095)
      scaled = 64'sd4095;
    return scaled[SINE_W-1:0];
  endfunction

endpackage

// File: rtl/ac_motor_control_sector_switch_if.sv
// Signal bundle between the motor controller front end and the sector
// switch block.
//   master: drives demand, control word, synced sector and vector strobes;
//           receives all registered outputs.
//   slave : the sector switch block itself.
// Handshake: there is no valid/ready pair. Every input is sampled on every
// rising clock edge and every output is a registered function of the
// inputs (or internal state) seen at the previous edge.
interface ac_motor_control_sector_switch_if;
  import ac_motor_control_sector_switch_pkg::*;

  logic [POWER_W-1:0]  power;
  logic [CTRL_W-1:0]   mod_delay_umin;
  logic [SECTOR_W-1:0] sector_synced;
  logic                u0;
  logic                u1;
  logic                u2;
  logic                u7;

  logic                modulation;
  logic [DELAY_W-1:0]  delay;
  logic [POWER_W-1:0]  frequency;
  logic [POWER_W-1:0]  u_str;
  logic [SECTOR_W-1:0] sector;
  logic [SINE_W-1:0]   sine_pos;
  logic [SINE_W-1:0]   sine_neg;
  logic                s1;
  logic                s2;
  logic                s3;

  modport master (
    output power, mod_delay_umin, sector_synced, u0, u1, u2, u7,
    input  modulation, delay, frequency, u_str, sector,
           sine_pos, sine_neg, s1, s2, s3
  );

  modport slave (
    input  power, mod_delay_umin, sector_synced, u0, u1, u2, u7,
    output modulation, delay, frequency, u_str, sector,
           sine_pos, sine_neg, s1, s2, s3
  );
endinterface

// File: rtl/ac_motor_control_sector_switch_sine_rom.sv
// ac_motor_sine_rom: 256 x 12-bit sine table covering 0..60 degrees with two
// independent registered read ports.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears read data)
//   addr_a, addr_b  8-bit read addresses
//   data_a, data_b  12-bit read data, valid one cycle after the address
module ac_motor_sine_rom
  import ac_motor_control_sector_switch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ANGLE_W-1:0] addr_a,
  input  logic [ANGLE_W-1:0] addr_b,
  output logic [SINE_W-1:0]  data_a,
  output logic [SINE_W-1:0]  data_b
);

  logic [SINE_W-1:0] rom_w [256];

  for (genvar i = 0; i < 256; i++) begin : g_entry
    localparam logic [SINE_W-1:0] ENTRY = sine_entry(i);
    assign rom_w[i] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= rom_w[addr_a];
      data_b <= rom_w[addr_b];
    end
  end

endmodule

// File: rtl/ac_motor_control_sector_switch.sv
// ac_motor_control_sector_switch: space-vector sector switch for an AC motor.
//   - control path: registers modulation/delay fields, frequency = power,
//     u_str = max(power, u_min*32) while modulation is on, else 0
//   - phase path: 20-bit accumulator advanced by frequency each clock; each
//     carry-out steps the 60-degree sector 0..5; the angle index drives a
//     sine ROM giving sin(angle) and sin(60deg - angle)
//   - switch path: active-vector strobes select the {s1,s2,s3} pattern for
//     the externally synced sector
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of ac_motor_control_sector_switch_if
module ac_motor_control_sector_switch
  import ac_motor_control_sector_switch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ac_motor_control_sector_switch_if.slave bus
);

  // ---------------- control path ----------------
  logic                modulation_q;
  logic [DELAY_W-1:0]  delay_q;
  logic [POWER_W-1:0]  frequency_q;
  logic [POWER_W-1:0]  u_str_q;

  logic [UMIN_W-1:0]   u_min;
  logic [POWER_W-1:0]  u_floor;

  assign u_min   = bus.mod_delay_umin[UMIN_MSB:UMIN_LSB];
  // 7-bit u_min times 32 peaks at 4064, so it always fits 12 bits.
  assign u_floor = {u_min, {UMIN_SHIFT{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      modulation_q <= 1'b0;
      delay_q      <= '0;
      frequency_q  <= '0;
      u_str_q      <= '0;
    end else begin
      modulation_q <= bus.mod_delay_umin[MOD_BIT];
      delay_q      <= bus.mod_delay_umin[DELAY_MSB:DELAY_LSB];
      frequency_q  <= bus.power;
      if (bus.mod_delay_umin[MOD_BIT])
        u_str_q <= (bus.power > u_floor) ? bus.power : u_floor;
      else
        u_str_q <= '0;
    end
  end

  // ---------------- phase accumulator / sector ----------------
  logic [ACC_W-1:0]    acc_q;
  logic [SECTOR_W-1:0] sector_q;
  logic [ACC_W:0]      acc_sum;

  // Driven by the registered frequency, so a zero demand freezes the phase.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W - POWER_W + 1){1'b0}}, frequency_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      sector_q <= '0;
    end else begin
      acc_q <= acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W])
        sector_q <= next_sector(sector_q);
    end
  end

  // ---------------- sine lookup ----------------
  logic [ANGLE_W-1:0] angle;
  logic [ANGLE_W-1:0] angle_comp;
  logic [SINE_W-1:0]  sine_pos_w;
  logic [SINE_W-1:0]  sine_neg_w;

  assign angle      = acc_q[ACC_W-1:ACC_W-ANGLE_W];
  assign angle_comp = 8'd255 - angle;

  ac_motor_sine_rom u_sine_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (angle),
    .addr_b (angle_comp),
    .data_a (sine_pos_w),
    .data_b (sine_neg_w)
  );

  // ---------------- switch path ----------------
  logic [2:0] sw_q;
  logic [2:0] u1_idx;
  logic [2:0] u2_idx;

  // u1 selects the vector leading the sector, u2 the one trailing it;
  // for sector 5 the trailing vector wraps back to V1.
  assign u1_idx = bus.sector_synced + 3'd1;
  assign u2_idx = (bus.sector_synced == SECTOR_LAST) ? 3'd1 : bus.sector_synced + 3'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q <= V0;
    end else if (bus.sector_synced > SECTOR_LAST) begin
      // An out-of-range synced sector is treated as a fault: all low.
      sw_q <= V0;
    end else if (bus.u0) begin
      sw_q <= V0;
    end else if (bus.u7) begin
      sw_q <= V7;
    end else if (bus.u1) begin
      sw_q <= vector_code(u1_idx);
    end else if (bus.u2) begin
      sw_q <= vector_code(u2_idx);
    end
  end

  // ---------------- outputs ----------------
  assign bus.modulation = modulation_q;
  assign bus.delay      = delay_q;
  assign bus.frequency  = frequency_q;
  assign bus.u_str      = u_str_q;
  assign bus.sector     = sector_q;
  assign bus.sine_pos   = sine_pos_w;
  assign bus.sine_neg   = sine_neg_w;
  assign bus.s1         = sw_q[2];
  assign bus.s2         = sw_q[1];
  assign bus.s3         = sw_q[0];

endmodule

// File: tb/tb_ac_motor_control_sector_switch.sv
// Bench for ac_motor_control_sector_switch: directed vectors, expected
// values pushed to a queue after each clock, popped and compared by an
// independent monitor on the falling edge.
module tb_ac_motor_control_sector_switch;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ac_motor_control_sector_switch_if bus ();

  ac_motor_control_sector_switch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  localparam logic [3:0] SEL_MOD   = 4'd0;
  localparam logic [3:0] SEL_DELAY = 4'd1;
  localparam logic [3:0] SEL_FREQ  = 4'd2;
  localparam logic [3:0] SEL_USTR  = 4'd3;
  localparam logic [3:0] SEL_SECT  = 4'd4;
  localparam logic [3:0] SEL_SPOS  = 4'd5;
  localparam logic [3:0] SEL_SNEG  = 4'd6;
  localparam logic [3:0] SEL_SW    = 4'd7;

  // strobe vector {u0, u1, u2, u7}
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_U0   = 4'b1000;
  localparam logic [3:0] S_U1   = 4'b0100;
  localparam logic [3:0] S_U2   = 4'b0010;
  localparam logic [3:0] S_U7   = 4'b0001;

  typedef struct packed {
    logic [3:0]  sel;
    logic [11:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        mon_e;
  logic [11:0] mon_act;
  logic [2:0]  frozen_sector;

  function automatic string sel_name(input logic [3:0] sel);
    case (sel)
      SEL_MOD:   return "modulation";
      SEL_DELAY: return "delay";
      SEL_FREQ:  return "frequency";
      SEL_USTR:  return "u_str";
      SEL_SECT:  return "sector";
      SEL_SPOS:  return "sine_pos";
      SEL_SNEG:  return "sine_neg";
      SEL_SW:    return "s1s2s3";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [11:0] observe(input logic [3:0] sel);
    case (sel)
      SEL_MOD:   return {11'd0, bus.modulation};
      SEL_DELAY: return {4'd0, bus.delay};
      SEL_FREQ:  return bus.frequency;
      SEL_USTR:  return bus.u_str;
      SEL_SECT:  return {9'd0, bus.sector};
      SEL_SPOS:  return bus.sine_pos;
      SEL_SNEG:  return bus.sine_neg;
      SEL_SW:    return {9'd0, bus.s1, bus.s2, bus.s3};
      default:   return 12'hxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = observe(mon_e.sel);
      n_vec++;
      if (mon_act !== mon_e.val) begin
        n_err++;
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                 sel_name(mon_e.sel), mon_act, mon_act, mon_e.val, mon_e.val, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input logic [3:0] sel, input logic [11:0] val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_all_zero();
    for (int i = 0; i <= 7; i++)
      expect_out(4'(i), 12'd0);
  endtask

  // Drive one cycle of inputs (reset released) and wait for the edge that
  // samples them.
  task automatic apply(input logic [11:0] p, input logic [15:0] m,
                       input logic [2:0] ss, input logic [3:0] strb);
    @(negedge clk);
    rst                = 1'b0;
    bus.power          = p;
    bus.mod_delay_umin = m;
    bus.sector_synced  = ss;
    bus.u0             = strb[3];
    bus.u1             = strb[2];
    bus.u2             = strb[1];
    bus.u7             = strb[0];
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    expect_all_zero();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst                = 1'b1;
    bus.power          = 12'h123;
    bus.mod_delay_umin = 16'hFFFF;
    bus.sector_synced  = 3'd1;
    bus.u0             = 1'b0;
    bus.u1             = 1'b0;
    bus.u2             = 1'b0;
    bus.u7             = 1'b1;

    // Reset dominates busy inputs.
    repeat (2) @(posedge clk);
    expect_all_zero();

    // Control path.
    apply(12'h100, 16'h8000, 3'd0, S_NONE);
    expect_out(SEL_FREQ, 12'h100);
    expect_out(SEL_USTR, 12'h100);
    expect_out(SEL_MOD, 12'd1);
    expect_out(SEL_DELAY, 12'd0);

    apply(12'h010, 16'h8064, 3'd0, S_NONE);
    expect_out(SEL_FREQ, 12'h010);
    expect_out(SEL_USTR, 12'd3200);

    apply(12'h010, 16'h0064, 3'd0, S_NONE);
    expect_out(SEL_USTR, 12'd0);
    expect_out(SEL_MOD, 12'd0);

    // delay field 0xA5, u_min 5 (160) below power 0x200
    apply(12'h200, 16'hD285, 3'd0, S_NONE);
    expect_out(SEL_DELAY, 12'hA5);
    expect_out(SEL_USTR, 12'h200);
    expect_out(SEL_MOD, 12'd1);

    // u_min at its maximum 127 -> floor 4064, power above it wins
    apply(12'hFFF, 16'h807F, 3'd0, S_NONE);
    expect_out(SEL_USTR, 12'hFFF);
    apply(12'h00F, 16'h807F, 3'd0, S_NONE);
    expect_out(SEL_USTR, 12'd4064);

    // Switch path.
    apply(12'h000, 16'h0000, 3'd2, S_U1);
    expect_out(SEL_SW, 12'b010);
    apply(12'h000, 16'h0000, 3'd2, S_NONE);
    expect_out(SEL_SW, 12'b010);
    apply(12'h000, 16'h0000, 3'd2, S_U2);
    expect_out(SEL_SW, 12'b011);
    apply(12'h000, 16'h0000, 3'd2, S_U7);
    expect_out(SEL_SW, 12'b111);
    apply(12'h000, 16'h0000, 3'd2, S_U0 | S_U7);
    expect_out(SEL_SW, 12'b000);
    apply(12'h000, 16'h0000, 3'd5, S_U2);
    expect_out(SEL_SW, 12'b100);
    apply(12'h000, 16'h0000, 3'd5, S_U1);
    expect_out(SEL_SW, 12'b101);
    apply(12'h000, 16'h0000, 3'd0, S_U2);
    expect_out(SEL_SW, 12'b110);
    apply(12'h000, 16'h0000, 3'd0, S_U1 | S_U2);
    expect_out(SEL_SW, 12'b100);
    apply(12'h000, 16'h0000, 3'd1, S_U7);
    expect_out(SEL_SW, 12'b111);
    apply(12'h000, 16'h0000, 3'd7, S_NONE);
    expect_out(SEL_SW, 12'b000);
    apply(12'h000, 16'h0000, 3'd6, S_U7);
    expect_out(SEL_SW, 12'b000);
    apply(12'h000, 16'h0000, 3'd3, S_U1);
    expect_out(SEL_SW, 12'b011);

    // Phase accumulator and sine: frequency 0x800 from reset.
    // After edge n (n >= 1) the accumulator holds n*0x800 mod 2^20,
    // the sector is (n/512) mod 6, and the sine outputs reflect the
    // angle index of the previous edge, ((n-1)/2) mod 256.
    do_reset(1);
    for (int n = 0; n <= 3072; n++) begin
      apply(12'h800, 16'h8000, 3'd0, S_NONE);
      if (n == 1) begin
        expect_out(SEL_FREQ, 12'h800);
        expect_out(SEL_SECT, 12'd0);
        expect_out(SEL_SPOS, 12'd0);
        expect_out(SEL_SNEG, 12'd3538);
      end
      if (n == 257)
        expect_out(SEL_SPOS, 12'd2048);
      if (n == 511) begin
        expect_out(SEL_SECT, 12'd0);
        expect_out(SEL_SPOS, 12'd3538);
        expect_out(SEL_SNEG, 12'd0);
      end
      if (n == 3071)
        expect_out(SEL_SECT, 12'd5);
      if (n % 512 == 0 && n != 0)
        expect_out(SEL_SECT, 12'((n / 512) % 6));
    end

    // Run into the middle of sector 0 again, load a switch state, then reset.
    for (int n = 0; n < 200; n++)
      apply(12'h800, 16'h8000, 3'd0, S_NONE);
    apply(12'h800, 16'h8000, 3'd0, S_U7);
    expect_out(SEL_SW, 12'b111);
    do_reset(1);

    // Phase restarts from zero after the reset.
    for (int n = 0; n <= 512; n++) begin
      apply(12'h800, 16'h0000, 3'd0, S_NONE);
      if (n == 1) begin
        expect_out(SEL_SPOS, 12'd0);
        expect_out(SEL_SNEG, 12'd3538);
      end
      if (n == 511)
        expect_out(SEL_SECT, 12'd0);
      if (n == 512)
        expect_out(SEL_SECT, 12'd1);
    end

    // Zero demand freezes the sector.
    apply(12'h000, 16'h0000, 3'd0, S_NONE);
    for (int n = 0; n < 600; n++) begin
      apply(12'h000, 16'h0000, 3'd0, S_NONE);
      if (n == 300) begin
        @(negedge clk);
        frozen_sector = bus.sector;
      end
    end
    expect_out(SEL_SECT, 12'd1);
    expect_out(SEL_FREQ, 12'd0);

    repeat (2) @(negedge clk);
    #1;

    if (bus.sector !== 3'd1) begin
      n_err++;
      $display("FAIL frozen sector: got %0d, expected 1", bus.sector);
    end
    if (bus.sector !== frozen_sector) begin
      n_err++;
      $display("FAIL sector moved during freeze: got %0d, expected %0d",
               bus.sector, frozen_sector);
    end
    if (bus.frequency !== 12'd0) begin
      n_err++;
      $display("FAIL frequency: got %0d, expected 0", bus.frequency);
    end
    if (bus.u_str !== 12'd0) begin
      n_err++;
      $display("FAIL u_str: got %0d, expected 0", bus.u_str);
    end
    if (bus.modulation !== 1'b0) begin
      n_err++;
      $display("FAIL modulation: got %0d, expected 0", bus.modulation);
    end
    if ({bus.s1, bus.s2, bus.s3} !== 3'b000) begin
      n_err++;
      $display("FAIL s1s2s3 hold: got %b, expected 000", {bus.s1, bus.s2, bus.s3});
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
